uart_frame_tx: RTL and testbench
================================

Name: uart_frame_tx

Overview:
UART transmit side of the host control link. It serializes a fixed 8-byte status/acknowledge frame (header, command, frequency word, amplitude word, checksum, tail) as 8N1 onto the tx line. The frame uses the same layout the host parser expects, so the FPGA can echo the frequency/amplitude settings it applied, or report errors. It runs in the system clock domain and generates its own bit timing, with no external baud tick.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2
HEADER, 8'hAA, frame byte 0
TAIL, 8'h55, frame byte 7

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
send  input  1  start request; sampled every cycle
cmd_in  input  8  command/status byte (byte 1)
freq_in  input  16  frequency word; bytes 2 (MSB) and 3 (LSB)
amp_in  input  16  amplitude word; bytes 4 (MSB) and 5 (LSB)
tx  output  1  UART serial out; idle high
busy  output  1  high while a frame is in flight
done  output  1  one-cycle pulse when the frame completes

Behaviour:
- Interface decided: one clock clk; reset rst is synchronous and active-high.
- Reset values: tx=1, busy=0, done=0. Internal state is IDLE, and the bit, byte and baud counters are 0.
- States: IDLE -> START -> DATA -> STOP -> (next byte: START | last byte: IDLE).
- Acceptance: send=1 in IDLE at cycle N latches cmd_in/freq_in/amp_in into a frame buffer. The checksum is computed from these latched values. Inputs may change freely after cycle N.
- Checksum byte 6 = (cmd + freq[15:8] + freq[7:0] + amp[15:8] + amp[7:0]) mod 256. Carries are discarded.
- Byte order: HEADER, cmd, freq MSB, freq LSB, amp MSB, amp LSB, checksum, TAIL.
- Bit order per byte: start bit (0), data LSB first, stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. There is no idle gap between bytes; a stop bit is followed directly by the next start bit.
- Timing from acceptance at cycle N:
  - tx=0 and busy=1 starting at cycle N+1.
  - A frame is 80 bit times, so busy=1 for cycles N+1 .. N+80*CLKS_PER_BIT.
  - At cycle N+80*CLKS_PER_BIT+1: done=1 for one cycle, busy=0, tx=1.
- send while busy=1: ignored. It is not queued, and the frame in flight is unaffected.
- send on the done cycle is accepted, since busy=0. The next start bit begins on the following cycle.
- send held high continuously: frames go out back to back, with one idle-high cycle (the done cycle) between them.
- Reset mid-frame: on the cycle after rst is sampled high, tx=1, busy=0, done=0. No done pulse is issued for the aborted frame. send in the same cycle as rst is ignored.
- tx is driven from a register, so there are no combinational glitches.

Test Plan:
- Basic frame, CLKS_PER_BIT=4: send pulse with cmd=8'h01, freq=16'h03E8, amp=16'h0002.
  - Decoded bytes must be AA 01 03 E8 00 02 EE 55.
  - Every bit is exactly 4 cycles wide, and start/stop bits are correct.
  - busy=1 for exactly 320 cycles, then done=1 for exactly 1 cycle.
- Checksum wrap: cmd=8'hFF, freq=16'hFFFF, amp=16'hFFFF -> checksum byte 8'hFB; all other bytes FF, with HEADER/TAIL intact.
- Ignored request: pulse send with different data at cycle 100 of a frame -> the frame in flight is unchanged, and no second frame follows done.
- Back-to-back: hold send=1 for two frames -> two complete frames with exactly one tx=1 cycle between the first frame's stop bit and the second frame's start bit. done pulses once per frame.
- Reset mid-frame: assert rst during byte 3, bit 5 -> tx=1 and busy=0 from the next cycle, no done pulse. A new send after release produces a complete, correct frame starting with AA.
- Input stability: change freq_in/amp_in every cycle after acceptance -> the transmitted bytes match the values present at the acceptance cycle.

Source files
------------

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: serializes a fixed 8-byte status/acknowledge frame as 8N1.
// Frame layout: HEADER, cmd, freq[15:8], freq[7:0], amp[15:8], amp[7:0],
// checksum, TAIL. Bit timing is generated locally from CLKS_PER_BIT.
// All outputs are registered; tx never glitches.
module uart_frame_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER       = 8'hAA,
  parameter logic [7:0]  TAIL         = 8'h55
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [7:0]  cmd_in,
  input  logic [15:0] freq_in,
  input  logic [15:0] amp_in,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Modular byte sum of the payload; carries beyond bit 7 are dropped.
  function automatic logic [7:0] frame_checksum(
    input logic [7:0]  cmd,
    input logic [15:0] freq,
    input logic [15:0] amp
  );
    logic [7:0] sum;
    sum = cmd + freq[15:8];
    sum = sum + freq[7:0];
    sum = sum + amp[15:8];
    sum = sum + amp[7:0];
    return sum;
  endfunction

  // Byte at a given frame position, built from the latched payload.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]  idx,
    input logic [7:0]  cmd,
    input logic [15:0] freq,
    input logic [15:0] amp,
    input logic [7:0]  csum
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = HEADER;
      3'd1:    b = cmd;
      3'd2:    b = freq[15:8];
      3'd3:    b = freq[7:0];
      3'd4:    b = amp[15:8];
      3'd5:    b = amp[7:0];
      3'd6:    b = csum;
      3'd7:    b = TAIL;
      default: b = HEADER;
    endcase
    return b;
  endfunction

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [15:0]   freq_q, freq_d;
  logic [15:0]   amp_q, amp_d;
  logic [7:0]    csum_q, csum_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_end_s;
  logic          frame_end_s;
  logic [7:0]    cur_byte_s;

  assign baud_end_s = (baud_q == BAUD_MAX);

  // FSM state, bit-timing counters and latched frame payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      cmd_q   <= 8'h00;
      freq_q  <= 16'h0000;
      amp_q   <= 16'h0000;
      csum_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      cmd_q   <= cmd_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      csum_q  <= csum_d;
    end
  end

  // Next-state logic: walk start/data/stop bits of each byte, 8 bytes per frame.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    cmd_d       = cmd_q;
    freq_d      = freq_q;
    amp_d       = amp_q;
    csum_d      = csum_q;
    frame_end_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (send) begin
          state_d = ST_START;
          baud_d  = '0;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
          cmd_d   = cmd_in;
          freq_d  = freq_in;
          amp_d   = amp_in;
          csum_d  = frame_checksum(cmd_in, freq_in, amp_in);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_end_s) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          baud_d  = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_end_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_end_s) begin
          baud_d = '0;
          if (byte_q == 3'd7) begin
            state_d     = ST_IDLE;
            byte_d      = 3'd0;
            frame_end_s = 1'b1;
          end else begin
            state_d = ST_START;
            byte_d  = byte_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = 3'd0;
        byte_d  = 3'd0;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    cur_byte_s = frame_byte(byte_d, cmd_q, freq_q, amp_q, csum_q);
    busy_d     = (state_d != ST_IDLE);
    done_d     = frame_end_s;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = cur_byte_s[bit_d];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // Output registers: tx idles high, busy/done low out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx with CLKS_PER_BIT=4. A frame-level timeline model
// predicts tx/busy/done every cycle; a line decoder reconstructs each frame's
// bytes, which directed tests compare against hand-computed literals.
module tb_uart_frame_tx;

  localparam int C         = 4;
  localparam int FRAME_CYC = 80 * C;

  logic        clk = 1'b0;
  logic        rst;
  logic        send;
  logic [7:0]  cmd_in;
  logic [15:0] freq_in;
  logic [15:0] amp_in;
  logic        tx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  uart_frame_tx #(
    .CLKS_PER_BIT(C),
    .HEADER(8'hAA),
    .TAIL(8'h55)
  ) dut (
    .clk(clk),
    .rst(rst),
    .send(send),
    .cmd_in(cmd_in),
    .freq_in(freq_in),
    .amp_in(amp_in),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] model_frame(input logic [7:0] c, input logic [15:0] f,
                                              input logic [15:0] a);
    logic [7:0] s;
    s = 8'((int'(c) + int'(f[15:8]) + int'(f[7:0]) + int'(a[15:8]) + int'(a[7:0])) % 256);
    return {8'hAA, c, f, a, s, 8'h55};
  endfunction

  function automatic logic [0:79] model_bits(input logic [63:0] fr);
    logic [0:79] r;
    for (int b = 0; b < 8; b++) begin
      r[b*10] = 1'b0;
      for (int i = 0; i < 8; i++) r[b*10+1+i] = fr[56-8*b+i];
      r[b*10+9] = 1'b1;
    end
    return r;
  endfunction

  logic        m_active = 1'b0;
  logic        m_done   = 1'b0;
  int          m_pos    = 0;
  logic [63:0] m_frame  = 64'h0;
  logic [0:79] m_bits   = '1;

  // Timeline: accepted frame occupies 80*C cycles, then one done cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_pos    <= 0;
    end else if (m_active) begin
      if (m_pos == FRAME_CYC) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_pos <= m_pos + 1;
      end
    end else begin
      m_done <= 1'b0;
      if (send) begin
        m_frame  <= model_frame(cmd_in, freq_in, amp_in);
        m_bits   <= model_bits(model_frame(cmd_in, freq_in, amp_in));
        m_active <= 1'b1;
        m_pos    <= 1;
      end
    end
  end

  // Per-cycle compare of the outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle_tx_busy_done", {61'h0, tx, busy, done},
            {61'h0, (m_active ? m_bits[(m_pos-1)/C] : 1'b1), m_active, m_done});
    end
  end

  // ---------------- line decoder ----------------
  logic [0:FRAME_CYC-1] samp;
  int          k = 0;
  int          done_count = 0;
  int          last_len = 0;
  logic [63:0] last_frame = 64'h0;
  logic        last_framing = 1'b0;

  function automatic logic [63:0] decode(input logic [0:FRAME_CYC-1] s);
    logic [63:0] r;
    r = 64'h0;
    for (int b = 0; b < 8; b++)
      for (int i = 0; i < 8; i++) r[56-8*b+i] = s[(b*10+1+i)*C + C/2];
    return r;
  endfunction

  function automatic logic framing(input logic [0:FRAME_CYC-1] s);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < C; j++)
        if (s[b*10*C + j] !== 1'b0 || s[(b*10+9)*C + j] !== 1'b1) ok = 1'b0;
    return ok;
  endfunction

  // Collect tx samples while busy; decode when done appears.
  always @(negedge clk) begin
    if (chk_en) begin
      if (busy) begin
        if (k < FRAME_CYC) samp[k] <= tx;
        k <= k + 1;
      end else begin
        if (done) begin
          done_count   <= done_count + 1;
          last_len     <= k;
          last_frame   <= decode(samp);
          last_framing <= framing(samp);
        end
        k <= 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [15:0] f, input logic [15:0] a);
    cmd_in  = c;
    freq_in = f;
    amp_in  = a;
    send    = 1'b1;
    tick();
    send    = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int prev;
    bit seen;
    prev = done_count;
    seen = 1'b0;
    for (int i = 0; i < FRAME_CYC + 40; i++) begin
      tick();
      if (done_count != prev) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_frame(input string name, input logic [63:0] exp);
    check({name, "_bytes"}, last_frame, exp);
    check({name, "_busy_len"}, 64'(last_len), 64'd320);
    check({name, "_framing"}, {63'h0, last_framing}, 64'd1);
  endtask

  initial begin
    int dc;
    bit seen;
    rst = 1'b1; send = 1'b0; cmd_in = 8'h00; freq_in = 16'h0000; amp_in = 16'h0000;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset_outputs", {61'h0, tx, busy, done}, 64'b100);
    rst = 1'b0;
    repeat (3) tick();

    // Basic frame
    send_frame(8'h01, 16'h03E8, 16'h0002);
    check("model_checksum", {56'h0, m_frame[15:8]}, 64'hEE);
    check("start_immediate", {62'h0, tx, busy}, 64'b01);
    wait_frame("basic");
    check_frame("basic", 64'hAA0103E80002EE55);
    check("done_one_cycle", {63'h0, done}, 64'd0);
    repeat (5) tick();

    // Checksum wrap
    send_frame(8'hFF, 16'hFFFF, 16'hFFFF);
    wait_frame("wrap");
    check_frame("wrap", 64'hAAFFFFFFFFFFFB55);
    repeat (5) tick();

    // Request while busy is ignored
    send_frame(8'h12, 16'h3456, 16'h789A);
    repeat (98) tick();
    send_frame(8'h77, 16'h7777, 16'h7777);
    wait_frame("ignored");
    check_frame("ignored", 64'hAA123456789AAE55);
    dc = done_count;
    repeat (400) tick();
    check("ignored_no_second", 64'(done_count - dc), 64'd0);
    check("ignored_idle_busy", {63'h0, busy}, 64'd0);

    // Back-to-back with send held
    dc = done_count;
    cmd_in = 8'hA1; freq_in = 16'hB2C3; amp_in = 16'hD4E5;
    send = 1'b1;
    wait_frame("b2b_first");
    check_frame("b2b_first", 64'hAAA1B2C3D4E5CF55);
    check("b2b_gap_one_cycle", {62'h0, tx, busy}, 64'b01);
    send = 1'b0;
    wait_frame("b2b_second");
    check_frame("b2b_second", 64'hAAA1B2C3D4E5CF55);
    check("b2b_done_count", 64'(done_count - dc), 64'd2);
    repeat (5) tick();

    // Reset during byte 3, data bit 5
    send_frame(8'h5A, 16'h1234, 16'h5678);
    repeat (144) tick();
    rst = 1'b1; send = 1'b1;
    tick();
    check("rst_abort_outputs", {61'h0, tx, busy, done}, 64'b100);
    rst = 1'b0; send = 1'b0;
    dc = done_count;
    repeat (400) tick();
    check("rst_no_done", 64'(done_count - dc), 64'd0);
    send_frame(8'h5A, 16'h1234, 16'h5678);
    wait_frame("after_rst");
    check_frame("after_rst", 64'hAA5A123456786E55);
    repeat (5) tick();

    // Inputs scrambled every cycle after acceptance
    send_frame(8'hC3, 16'h0F0F, 16'hF0F0);
    dc = done_count;
    seen = 1'b0;
    for (int i = 0; i < FRAME_CYC + 40; i++) begin
      cmd_in  = 8'($urandom);
      freq_in = 16'($urandom);
      amp_in  = 16'($urandom);
      tick();
      if (done_count != dc) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("stable_timeout", 64'd0, 64'd1);
    check_frame("stable", 64'hAAC30F0FF0F0C155);
    repeat (5) tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
